// File: rtl/logic_unit_pkg.sv
// Shared constants and types for the arbitrated bitwise logic unit.
package logic_unit_pkg;

    localparam int W = 20;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit_w.sv
// Combinational W-bit bitwise logic unit: AND, OR, XOR, NAND.
module logic_unit_w #(
    parameter int W = logic_unit_pkg::W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y
);
    import logic_unit_pkg::*;

    always_comb begin
        // NOTE: y gets a default before the case so no path can leave it unassigned and infer a latch.
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit between two requesters.
module logic_unit_arbiter #(
    parameter int W     = logic_unit_pkg::W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [1:0]       op0,
    input  logic             req1,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    input  logic [1:0]       op1,
    output logic             ack0,
    output logic             ack1,
    output logic [W-1:0]     result,
    output logic             busy,
    output logic             gnt,
    output logic [CNT_W-1:0] op_count
);
    import logic_unit_pkg::*;

    state_t       state;
    logic         last_gnt;
    logic         winner;
    logic         grant;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [1:0]   op_q;
    logic [W-1:0] y;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        winner = (req0 && req1) ? ~last_gnt : req1;
        grant  = (state == S_IDLE) && (req0 || req1);
    end

    // NOTE: operand registers carry no reset; they are always loaded at the grant before being consumed.
    always_ff @(posedge clk) begin
        if (grant) begin
            a_q  <= winner ? a1  : a0;
            b_q  <= winner ? b1  : b0;
            op_q <= winner ? op1 : op0;
        end
    end

    logic_unit_w #(.W(W)) u_logic_unit (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (y)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            last_gnt <= 1'b1;
            gnt      <= 1'b0;
            result   <= '0;
            op_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        gnt      <= winner;
                        last_gnt <= winner;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    result <= y;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    op_count <= op_count + 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign ack0 = (state == S_DONE) && !gnt;
    assign ack1 = (state == S_DONE) &&  gnt;

endmodule
